rs_pipe_chain: RTL

//  Parametrised chain of STAGES valid/ready register slices between one upstream (s_*) and one downstream (m_*) stream.
//  Per-build MODE selects forward-only, backward-only (skid), or full (backward then forward) slices per stage.

---
 rtl/rs_pipe_chain.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rs_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module   : rs_pipe_chain
//  Purpose  : Cascade of STAGES valid/ready register slices (forward, skid or
//             full) with synchronous flush and live occupancy count.
//             Optional RS_PIPE_CHAIN_BEATCNT_EN adds a 32-bit m-side beat counter.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_pipe_chain #(
    parameter int DWIDTH = 32,
    parameter int STAGES = 2,
    parameter int MODE   = 2,
    parameter int OCC_W  = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready,
    output logic [OCC_W-1:0]  occupancy
`ifdef RS_PIPE_CHAIN_BEATCNT_EN
    ,
    output logic [31:0]       beat_cnt
`endif
);

    if (MODE < 0 || MODE > 2 || STAGES < 1) begin : g_bad_cfg
        $error("rs_pipe_chain: unsupported MODE or STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              w_in_valid;
        logic              w_in_ready;
        logic [DWIDTH-1:0] w_in_data;
        logic              w_out_valid;
        logic              w_out_ready;
        logic [DWIDTH-1:0] w_out_data;
        logic              w_fv;
        logic              w_bv;
        logic [OCC_W-1:0]  w_occ_acc;

        // Flush masks the chain ends so nothing transfers in the flush cycle.
        if (k == 0) begin : g_head
            assign w_in_valid = s_valid & ~flush;
            assign w_in_data  = s_data;
            assign w_occ_acc  = OCC_W'(w_fv) + OCC_W'(w_bv);
        end else begin : g_link
            assign w_in_valid = g_stage[k-1].w_out_valid;
            assign w_in_data  = g_stage[k-1].w_out_data;
            assign w_occ_acc  = g_stage[k-1].w_occ_acc + OCC_W'(w_fv) + OCC_W'(w_bv);
        end

        if (k == STAGES-1) begin : g_tail
            assign w_out_ready = m_ready & ~flush;
        end else begin : g_mid
            assign w_out_ready = g_stage[k+1].w_in_ready;
        end

        if (MODE == 0) begin : g_fwd
            logic              r_v;
            logic [DWIDTH-1:0] r_d;

            assign w_in_ready  = ~r_v | w_out_ready;
            assign w_out_valid = r_v;
            assign w_out_data  = r_d;
            assign w_fv        = r_v;
            assign w_bv        = 1'b0;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_v <= 1'b0;
                end else if (w_in_ready) begin
                    r_v <= w_in_valid;
                end
                if (w_in_valid && w_in_ready) begin
                    r_d <= w_in_data;
                end
            end
        end else if (MODE == 1) begin : g_bwd
            logic              r_sv;
            logic [DWIDTH-1:0] r_sd;

            assign w_in_ready  = ~r_sv;
            assign w_out_valid = w_in_valid | r_sv;
            assign w_out_data  = r_sv ? r_sd : w_in_data;
            assign w_fv        = 1'b0;
            assign w_bv        = r_sv;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_sv <= 1'b0;
                end else if (w_out_ready) begin
                    r_sv <= 1'b0;
                end else if (w_in_valid) begin
                    r_sv <= 1'b1;
                end
                if (w_in_valid && !r_sv && !w_out_ready) begin
                    r_sd <= w_in_data;
                end
            end
        end else begin : g_full
            logic              r_sv;
            logic [DWIDTH-1:0] r_sd;
            logic              r_v;
            logic [DWIDTH-1:0] r_d;
            logic              w_mid_valid;
            logic              w_mid_ready;
            logic [DWIDTH-1:0] w_mid_data;

            // Skid half isolates upstream ready; register half isolates downstream valid/data.
            assign w_in_ready  = ~r_sv;
            assign w_mid_valid = w_in_valid | r_sv;
            assign w_mid_data  = r_sv ? r_sd : w_in_data;
            assign w_mid_ready = ~r_v | w_out_ready;
            assign w_out_valid = r_v;
            assign w_out_data  = r_d;
            assign w_fv        = r_v;
            assign w_bv        = r_sv;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_sv <= 1'b0;
                    r_v  <= 1'b0;
                end else begin
                    if (w_mid_ready) begin
                        r_sv <= 1'b0;
                    end else if (w_in_valid) begin
                        r_sv <= 1'b1;
                    end
                    if (w_mid_ready) begin
                        r_v <= w_mid_valid;
                    end
                end
                if (w_in_valid && !r_sv && !w_mid_ready) begin
                    r_sd <= w_in_data;
                end
                if (w_mid_valid && w_mid_ready) begin
                    r_d <= w_mid_data;
                end
            end
        end
    end

    assign s_ready   = g_stage[0].w_in_ready & ~flush;
    assign m_valid   = g_stage[STAGES-1].w_out_valid & ~flush;
    assign m_data    = g_stage[STAGES-1].w_out_data;
    assign occupancy = g_stage[STAGES-1].w_occ_acc;

`ifdef RS_PIPE_CHAIN_BEATCNT_EN
    logic [31:0] r_beat_cnt;

    // Survives flush on purpose: counts delivered beats over the whole session.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= 32'd0;
        end else if (m_valid && m_ready) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule
`default_nettype wire
